// File: rtl/exc_defs.sv
// Shared definitions for the exception sequencer: cause codes, FSM state
// encoding, default vector addresses and the write-back select code.
package exc_defs;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_OPCODE = 2'd1,
        CAUSE_OVF    = 2'd2,
        CAUSE_DIV0   = 2'd3
    } cause_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_READ    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_LATCH   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int unsigned VEC_OPCODE_DEFAULT = 253;
    localparam int unsigned VEC_OVF_DEFAULT    = 254;
    localparam int unsigned VEC_DIV0_DEFAULT   = 255;

    // Write-back mux select code that routes exception_address to the register file.
    localparam logic [1:0] WB_SEL_EXC = 2'd3;

    // Highest-priority cause among simultaneous requests: opcode > overflow > div0.
    function automatic cause_t prio_cause(input logic op, input logic ovf, input logic div0);
        if (op)
            return CAUSE_OPCODE;
        else if (ovf)
            return CAUSE_OVF;
        else if (div0)
            return CAUSE_DIV0;
        else
            return CAUSE_NONE;
    endfunction

    // Lower non-zero code wins, so merging is a min over the non-zero codes.
    function automatic cause_t merge_cause(input cause_t a, input cause_t b);
        if (a == CAUSE_NONE)
            return b;
        else if (b == CAUSE_NONE)
            return a;
        else
            return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Memory read port used by the exception sequencer to fetch handler vectors.
interface exception_sequencer_if;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data_in;

    modport master (output mem_addr, output mem_rd, input mem_data_in);
    modport slave  (input mem_addr, input mem_rd, output mem_data_in);
endinterface

// File: rtl/exc_byte_lane_sel.sv
// Picks one byte of a memory word by its low address bits and zero-extends it.
module exc_byte_lane_sel (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    output logic [31:0] zext
);
    logic [7:0] lanes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = word[8*gi +: 8];
    end

    assign zext = {24'b0, lanes[lane]};
endmodule

// File: rtl/exception_sequencer.sv
// Multicycle exception handler: saves EPC, fetches the handler vector byte and
// presents it for write-back. Optional EXC_PENDING_EN queues requests seen while busy.
module exception_sequencer
    import exc_defs::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned VEC_OPCODE  = VEC_OPCODE_DEFAULT,
    parameter int unsigned VEC_OVF     = VEC_OVF_DEFAULT,
    parameter int unsigned VEC_DIV0    = VEC_DIV0_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exc_opcode,
    input  logic                         exc_overflow,
    input  logic                         exc_div0,
    input  logic [31:0]                  pc_in,
    exception_sequencer_if.master        mem,
    output logic [31:0]                  epc_out,
    output logic                         epc_we,
    output logic [31:0]                  exception_address,
    output logic [1:0]                   exc_cause,
    output logic                         busy,
    output logic                         done
);
    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic [31:0] mem_addr_reg;
    logic        mem_rd_reg;
    logic [31:0] lane_word;
    cause_t      req_cause;
    cause_t      start_cause;

    assign mem.mem_addr = mem_addr_reg;
    assign mem.mem_rd   = mem_rd_reg;
    assign req_cause    = prio_cause(exc_opcode, exc_overflow, exc_div0);

    exc_byte_lane_sel u_lane_sel (
        .word (mem.mem_data_in),
        .lane (mem_addr_reg[1:0]),
        .zext (lane_word)
    );

    function automatic logic [31:0] vec_addr(input logic [1:0] cause);
        case (cause)
            CAUSE_OPCODE: return 32'(VEC_OPCODE);
            CAUSE_OVF:    return 32'(VEC_OVF);
            default:      return 32'(VEC_DIV0);
        endcase
    endfunction

`ifdef EXC_PENDING_EN
    cause_t pending_reg;
    assign start_cause = merge_cause(req_cause, pending_reg);
`else
    assign start_cause = req_cause;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= ST_IDLE;
            cnt_reg           <= '0;
            mem_addr_reg      <= '0;
            mem_rd_reg        <= 1'b0;
            epc_out           <= '0;
            epc_we            <= 1'b0;
            exception_address <= '0;
            exc_cause         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
`ifdef EXC_PENDING_EN
            pending_reg       <= CAUSE_NONE;
`endif
        end else begin
            epc_we     <= 1'b0;
            mem_rd_reg <= 1'b0;
            done       <= 1'b0;
`ifdef EXC_PENDING_EN
            // Remember the most urgent request that arrives mid-sequence.
            if (state_reg != ST_IDLE)
                pending_reg <= merge_cause(pending_reg, req_cause);
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (start_cause != CAUSE_NONE) begin
                        exc_cause <= start_cause;
                        epc_out   <= pc_in - 32'd4;
                        epc_we    <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= ST_CAPTURE;
`ifdef EXC_PENDING_EN
                        pending_reg <= CAUSE_NONE;
`endif
                    end
                end
                ST_CAPTURE: begin
                    mem_addr_reg <= vec_addr(exc_cause);
                    mem_rd_reg   <= 1'b1;
                    state_reg    <= ST_READ;
                end
                ST_READ: begin
                    cnt_reg   <= LAT;
                    state_reg <= (LAT == 3'd0) ? ST_LATCH : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg <= 3'd1)
                        state_reg <= ST_LATCH;
                end
                ST_LATCH: begin
                    exception_address <= lane_word;
                    done              <= 1'b1;
                    state_reg         <= ST_DONE;
                end
                ST_DONE: begin
`ifdef EXC_PENDING_EN
                    if (pending_reg != CAUSE_NONE) begin
                        exc_cause   <= pending_reg;
                        epc_out     <= pc_in - 32'd4;
                        epc_we      <= 1'b1;
                        pending_reg <= CAUSE_NONE;
                        state_reg   <= ST_CAPTURE;
                    end else begin
                        busy         <= 1'b0;
                        mem_addr_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end
`else
                    busy         <= 1'b0;
                    mem_addr_reg <= '0;
                    state_reg    <= ST_IDLE;
`endif
                end
                default: begin
                    busy         <= 1'b0;
                    mem_addr_reg <= '0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: one DUT with MEM_LATENCY=1, one with 0.
module tb_exception_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        exc_opcode, exc_overflow, exc_div0;
    logic        exc0_opcode, exc0_overflow, exc0_div0;
    logic [31:0] pc_in;
    logic [31:0] epc_out, exception_address, epc_out0, exception_address0;
    logic        epc_we, busy, done, epc_we0, busy0, done0;
    logic [1:0]  exc_cause, exc_cause0;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt;

    exception_sequencer_if mem_if ();
    exception_sequencer_if mem0_if ();

    always #5 clk = ~clk;

    exception_sequencer #(.MEM_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
        .pc_in(pc_in), .mem(mem_if),
        .epc_out(epc_out), .epc_we(epc_we), .exception_address(exception_address),
        .exc_cause(exc_cause), .busy(busy), .done(done)
    );

    exception_sequencer #(.MEM_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc0_opcode), .exc_overflow(exc0_overflow), .exc_div0(exc0_div0),
        .pc_in(pc_in), .mem(mem0_if),
        .epc_out(epc_out0), .epc_we(epc_we0), .exception_address(exception_address0),
        .exc_cause(exc_cause0), .busy(busy0), .done(done0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_epc"}, epc_out, 32'd0);
        chk({tag, "_epcwe"}, 32'(epc_we), 32'd0);
        chk({tag, "_exca"}, exception_address, 32'd0);
        chk({tag, "_cause"}, 32'(exc_cause), 32'd0);
        chk({tag, "_maddr"}, mem_if.mem_addr, 32'd0);
        chk({tag, "_mrd"}, 32'(mem_if.mem_rd), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        {exc_opcode, exc_overflow, exc_div0} = 3'b000;
        {exc0_opcode, exc0_overflow, exc0_div0} = 3'b000;
        pc_in = 32'h0;
        mem_if.mem_data_in = 32'h0;
        mem0_if.mem_data_in = 32'h0;
        tick();
        tick();
        chk_idle_zero("rst");
        chk("rst0_busy", 32'(busy0), 32'd0);
        reset = 1'b1;
        tick();

        // Overflow, MEM_LATENCY=1
        exc_overflow = 1'b1; pc_in = 32'h40; mem_if.mem_data_in = 32'h00AB0000;
        tick();
        exc_overflow = 1'b0;
        $display("txn ovf: cycle1 epc=%h we=%b cause=%0d", epc_out, epc_we, exc_cause);
        chk("ovf_c1_epc", epc_out, 32'h3C);
        chk("ovf_c1_we", 32'(epc_we), 32'd1);
        chk("ovf_c1_busy", 32'(busy), 32'd1);
        chk("ovf_c1_cause", 32'(exc_cause), 32'd2);
        tick();
        chk("ovf_c2_addr", mem_if.mem_addr, 32'd254);
        chk("ovf_c2_rd", 32'(mem_if.mem_rd), 32'd1);
        chk("ovf_c2_we", 32'(epc_we), 32'd0);
        tick();
        chk("ovf_c3_rd", 32'(mem_if.mem_rd), 32'd0);
        chk("ovf_c3_done", 32'(done), 32'd0);
        tick();
        chk("ovf_c4_addr", mem_if.mem_addr, 32'd254);
        chk("ovf_c4_done", 32'(done), 32'd0);
        tick();
        chk("ovf_c5_done", 32'(done), 32'd1);
        chk("ovf_c5_exca", exception_address, 32'h000000AB);
        tick();
        chk("ovf_c6_done", 32'(done), 32'd0);
        chk("ovf_c6_busy", 32'(busy), 32'd0);
        chk("ovf_c6_addr", mem_if.mem_addr, 32'd0);
        chk("ovf_c6_exca_hold", exception_address, 32'h000000AB);
        chk("ovf_c6_epc_hold", epc_out, 32'h3C);

        // Opcode + div0 together: opcode wins, lane 1
        exc_opcode = 1'b1; exc_div0 = 1'b1; pc_in = 32'h100; mem_if.mem_data_in = 32'h00001200;
        tick();
        exc_opcode = 1'b0; exc_div0 = 1'b0;
        $display("txn op+div0: cause=%0d epc=%h", exc_cause, epc_out);
        chk("prio_cause", 32'(exc_cause), 32'd1);
        chk("prio_epc", epc_out, 32'hFC);
        tick();
        chk("prio_addr", mem_if.mem_addr, 32'd253);
        repeat (3) tick();
        chk("prio_done", 32'(done), 32'd1);
        chk("prio_exca", exception_address, 32'h12);
        tick();

        // MEM_LATENCY=0, div0, lane 3
        exc0_div0 = 1'b1; mem0_if.mem_data_in = 32'hFF000000;
        tick();
        exc0_div0 = 1'b0;
        chk("l0_cause", 32'(exc_cause0), 32'd3);
        tick();
        chk("l0_addr", mem0_if.mem_addr, 32'd255);
        chk("l0_rd", 32'(mem0_if.mem_rd), 32'd1);
        tick();
        chk("l0_c3_done", 32'(done0), 32'd0);
        tick();
        $display("txn l0 div0: done=%b exca=%h", done0, exception_address0);
        chk("l0_c4_done", 32'(done0), 32'd1);
        chk("l0_c4_exca", exception_address0, 32'hFF);
        tick();
        chk("l0_c5_busy", 32'(busy0), 32'd0);

        // EPC wrap at pc_in=0
        exc_opcode = 1'b1; pc_in = 32'h0; mem_if.mem_data_in = 32'h00003400;
        tick();
        exc_opcode = 1'b0;
        $display("txn pc0: epc=%h", epc_out);
        chk("wrap_epc", epc_out, 32'hFFFFFFFC);
        repeat (4) tick();
        chk("wrap_exca", exception_address, 32'h34);
        tick();

        // Reset held two cycles mid-WAIT
        exc_overflow = 1'b1; pc_in = 32'h80; mem_if.mem_data_in = 32'h00CD0000;
        tick();
        exc_overflow = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_idle_zero("rstw1");
        tick();
        chk_idle_zero("rstw2");
        reset = 1'b1;
        done_cnt = 0;
        repeat (4) begin
            tick();
            if (done) done_cnt++;
        end
        $display("txn mid-wait reset: done pulses after release=%0d", done_cnt);
        chk("rstw_no_done", 32'(done_cnt), 32'd0);
        chk("rstw_idle", 32'(busy), 32'd0);

        // div0 pulse during WAIT
        exc_overflow = 1'b1; pc_in = 32'h200; mem_if.mem_data_in = 32'h55AA0000;
        tick();
        exc_overflow = 1'b0;
        tick();
        tick();
        exc_div0 = 1'b1;
        tick();
        exc_div0 = 1'b0;
        tick();
        chk("pend_first_done", 32'(done), 32'd1);
        chk("pend_first_exca", exception_address, 32'hAA);
        tick();
`ifdef EXC_PENDING_EN
        chk("pend_c6_busy", 32'(busy), 32'd1);
        chk("pend_c6_we", 32'(epc_we), 32'd1);
        chk("pend_c6_cause", 32'(exc_cause), 32'd3);
        chk("pend_c6_epc", epc_out, 32'h1FC);
        tick();
        chk("pend_c7_addr", mem_if.mem_addr, 32'd255);
        chk("pend_c7_rd", 32'(mem_if.mem_rd), 32'd1);
        repeat (3) tick();
        $display("txn pending div0: done=%b exca=%h", done, exception_address);
        chk("pend_c10_done", 32'(done), 32'd1);
        chk("pend_c10_exca", exception_address, 32'h55);
        tick();
        chk("pend_c11_busy", 32'(busy), 32'd0);
`else
        chk("drop_c6_busy", 32'(busy), 32'd0);
        chk("drop_c6_we", 32'(epc_we), 32'd0);
        done_cnt = 0;
        repeat (6) begin
            tick();
            if (done) done_cnt++;
        end
        $display("txn dropped div0: extra done pulses=%0d", done_cnt);
        chk("drop_no_done", 32'(done_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Multicycle exception handler sitting directly upstream of the write-back select mux.
- On an invalid-opcode, overflow or divide-by-zero event it saves EPC and fetches the 8-bit handler vector byte from memory address 253, 254 or 255.
- It presents that byte zero-extended on exception_address; control then selects it at write-back (select code 3).

Parameters:
- MEM_LATENCY, 1, memory read latency in cycles (0..7) between mem_rd and valid mem_data_in.
- VEC_OPCODE, 253, byte address of the invalid-opcode vector.
- VEC_OVF, 254, byte address of the overflow vector.
- VEC_DIV0, 255, byte address of the divide-by-zero vector.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low: the block resets on a rising clk edge while reset==0.
- exc_opcode  in  1  invalid-opcode request; sampled in IDLE only.
- exc_overflow  in  1  ALU overflow request; sampled in IDLE only.
- exc_div0  in  1  divide-by-zero request; sampled in IDLE only.
- pc_in  in  32  current PC, already incremented by 4.
- mem_data_in  in  32  word read from memory.
- mem_addr  out  32  byte address of the vector.
- mem_rd  out  1  memory read strobe.
- epc_out  out  32  saved EPC value.
- epc_we  out  1  EPC register write enable.
- exception_address  out  32  zero-extended vector byte; consumed by the write-back mux.
- exc_cause  out  2  latched cause code.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs are 0; state is IDLE. Reset in any state aborts the sequence and returns to IDLE on that edge.
- Priority when several requests are high at once: opcode > overflow > div0.
- Cause encoding: 0 none, 1 opcode, 2 overflow, 3 div0.
- FSM states: IDLE, CAPTURE, READ, WAIT, LATCH, DONE.
- IDLE: if any request is high, latch exc_cause and go to CAPTURE. Otherwise stay in IDLE.
- CAPTURE (1 cycle):
  - epc_out <= pc_in - 4, computed modulo 2^32, so pc_in=0 gives 0xFFFFFFFC.
  - epc_we = 1 in this state only.
  - Next state: READ.
- READ (1 cycle):
  - mem_addr = vector address for the latched cause; mem_rd = 1 in this state only.
  - Load the wait counter with MEM_LATENCY.
  - Next state: WAIT, or LATCH if MEM_LATENCY == 0.
- WAIT: decrement the counter each cycle; go to LATCH when it reaches 0.
- LATCH:
  - Select byte lane addr[1:0]: lane n is mem_data_in[8n+7:8n].
  - exception_address <= {24'b0, byte}.
  - Next state: DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Hold rules:
  - mem_addr holds its value from READ through LATCH and returns to 0 in IDLE.
  - exception_address and epc_out hold until the next LATCH or CAPTURE respectively.
- Latency: the request is seen in IDLE at cycle 0; done is high at cycle 4 + MEM_LATENCY.
- Requests arriving while busy=1 are ignored, unless the optional feature below is compiled in.

Optional Feature:
- Macro: EXC_PENDING_EN.
- Defined:
  - A 2-bit pending register records the highest-priority request seen while busy.
  - On leaving DONE the FSM goes straight to CAPTURE with that cause; it does not re-sample in IDLE.
  - The pending register clears on that transition and on reset.
- Undefined: requests during busy are dropped; there is no pending register.

Decomposition:
- Shared package/header exc_defs:
  - cause codes;
  - state encoding (3-bit);
  - default vector addresses 253/254/255;
  - write-back select code 3 for exception_address.
- One sub-module, exc_byte_lane_sel: combinational 32->8 lane select on addr[1:0] plus zero-extend to 32 bits.

Test Plan:
- reset=0 for 2 cycles mid-WAIT -> all outputs 0, IDLE next cycle, no done pulse.
- exc_overflow=1, pc_in=0x00000040, mem_data_in=0x00AB0000 -> epc_out=0x3C with epc_we at cycle 1; mem_addr=254 with mem_rd at cycle 2; exception_address=0x000000AB; done at cycle 5 (MEM_LATENCY=1).
- exc_opcode=1 and exc_div0=1 together -> exc_cause=1, mem_addr=253, lane 1 selected (mem_data_in=0x00001200 gives 0x12).
- MEM_LATENCY=0, exc_div0=1, mem_data_in=0xFF000000 -> exception_address=0xFF, done at cycle 4.
- exc_div0 pulsed during WAIT, macro off -> single done pulse; macro on -> second sequence with mem_addr=255, starting the cycle after the first done.
- pc_in=0x00000000, exc_opcode=1 -> epc_out=0xFFFFFFFC.
